line_fill_unit: RTL

- Miss-side refill engine directly upstream of the per-line data storage.
- On a cache miss, issues one critical-word-first burst request to memory.
- Collects four 32-bit return beats, wrapping the slot index, into a 128-bit line buffer.
- Presents the assembled line with a one-cycle load strobe, which drives the data line's full-line load and 128-bit data input.
- Forwards the critical word early so the stalled read can complete.

---
 rtl/line_fill_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/line_fill_unit.sv
// Miss-side refill engine: issues a critical-word-first burst, gathers four
// wrapping beats into a line buffer and strobes the finished line into storage.
module line_fill_unit #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned BEAT_W  = 32,
   parameter int unsigned INDEX_W = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  miss_req,
   input  logic [ADDR_W-1:0]     miss_addr,
   output logic                  miss_busy,
   output logic                  mem_req,
   output logic [ADDR_W-1:0]     mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [BEAT_W-1:0]     mem_rdata,
   output logic                  crit_valid,
   output logic [BEAT_W-1:0]     crit_data,
   output logic                  fill_load,
   output logic [INDEX_W-1:0]    fill_index,
   output logic [4*BEAT_W-1:0]   fill_data
);

   localparam int unsigned LINE_W = 4 * BEAT_W;

   typedef enum logic [1:0] {IDLE, REQ, RECV, LOAD} state_t;

   state_t               state_q, state_d;
   logic [1:0]           ci_q, ci_d;
   logic [1:0]           cnt_q, cnt_d;
   logic [INDEX_W-1:0]   idx_q, idx_d;
   logic [LINE_W-1:0]    line_q, line_d;
   logic                 miss_busy_d, mem_req_d, crit_valid_d, fill_load_d;
   logic [ADDR_W-1:0]    mem_addr_d;
   logic [BEAT_W-1:0]    crit_data_d;
   logic [INDEX_W-1:0]   fill_index_d;
   logic [1:0]           slot;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ci_q       <= '0;
         cnt_q      <= '0;
         idx_q      <= '0;
         line_q     <= '0;
         miss_busy  <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         crit_valid <= 1'b0;
         crit_data  <= '0;
         fill_load  <= 1'b0;
         fill_index <= '0;
      end else begin
         state_q    <= state_d;
         ci_q       <= ci_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         line_q     <= line_d;
         miss_busy  <= miss_busy_d;
         mem_req    <= mem_req_d;
         mem_addr   <= mem_addr_d;
         crit_valid <= crit_valid_d;
         crit_data  <= crit_data_d;
         fill_load  <= fill_load_d;
         fill_index <= fill_index_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      ci_d         = ci_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      line_d       = line_q;
      miss_busy_d  = miss_busy;
      mem_req_d    = mem_req;
      mem_addr_d   = mem_addr;
      crit_valid_d = 1'b0;
      crit_data_d  = crit_data;
      fill_load_d  = 1'b0;
      fill_index_d = fill_index;
      slot         = ci_q + cnt_q;

      case (state_q)
         IDLE: begin
            if (miss_req) begin
               state_d     = REQ;
               ci_d        = miss_addr[3:2];
               idx_d       = miss_addr[INDEX_W+3:4];
               cnt_d       = 2'd0;
               miss_busy_d = 1'b1;
               mem_req_d   = 1'b1;
               mem_addr_d  = {miss_addr[ADDR_W-1:2], 2'b00};
            end
         end
         REQ: begin
            if (mem_gnt) begin
               state_d   = RECV;
               mem_req_d = 1'b0;
            end
         end
         RECV: begin
            if (mem_rvalid) begin
               // Beat lands in its wrapped slot; untouched slots keep old data
               for (int k = 0; k < 4; k++) begin
                  if (2'(k) == slot) line_d[k*BEAT_W +: BEAT_W] = mem_rdata;
               end
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd0) begin
                  crit_valid_d = 1'b1;
                  crit_data_d  = mem_rdata;
               end
               if (cnt_q == 2'd3) begin
                  state_d      = LOAD;
                  fill_load_d  = 1'b1;
                  fill_index_d = idx_q;
               end
            end
         end
         LOAD: begin
            state_d     = IDLE;
            miss_busy_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   assign fill_data = line_q;

endmodule
